stage_memory: RTL and testbench

Pipeline stage directly downstream of the execute stage. It consumes the registered ALU result, destination register and control flags, and performs load/store accesses to data memory over a valid/ready request bus with a response channel. It produces the write-back value, destination and write-enable for the register file, and stalls upstream while a memory access is outstanding.

---
 rtl/stage_memory.sv | 165 ++++++++++++++++
 tb/tb_stage_memory.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// Memory pipeline stage: passes ALU results through, or performs one load/store
// over a valid/ready request bus with a response channel, stalling upstream meanwhile.
module stage_memory #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] execute_alu_result,
    input  logic [31:0] execute_store_data,
    input  logic [4:0]  execute_rd,
    input  logic        execute_wr_enable,
    input  logic        execute_mem_to_reg,
    input  logic        execute_mem_write,
    input  logic [2:0]  execute_funct3,
    output logic        stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic [31:0] memory_result,
    output logic [4:0]  memory_rd,
    output logic        memory_wr_enable,
    output logic        memory_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [8:0]  cnt_inc;
    logic        timeout_hit;
    logic [1:0]  off_l;
    logic [2:0]  f3_l;
    logic        wr_en_l;
    logic        is_load, is_store, mem_op;
    logic        f3_legal, aligned, bad_op;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
        case (f3[1:0])
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_extract = {24'h0, sh[7:0]};
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_extract = {16'h0, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    assign is_load  = execute_mem_to_reg;
    assign is_store = execute_mem_write;
    assign mem_op   = is_load | is_store;

    always_comb begin
        f3_legal = 1'b0;
        case (execute_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
    end

    assign aligned = (execute_funct3[1:0] == 2'b01) ? ~execute_alu_result[0] :
                     (execute_funct3[1:0] == 2'b10) ? (execute_alu_result[1:0] == 2'b00) : 1'b1;
    assign bad_op  = (is_load & is_store) | ~f3_legal | ~aligned;

    assign cnt_inc     = {1'b0, cnt} + 9'd1;
    assign timeout_hit = (cnt_inc >= 9'(RSP_TIMEOUT));

    assign stall          = ((state == IDLE) & mem_op) | (state == REQ) | (state == WAIT_RSP);
    assign dmem_req_valid = (state == REQ);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mem_op) state_next = bad_op ? DONE : REQ;
            REQ:      if (dmem_req_ready) state_next = dmem_we ? DONE : WAIT_RSP;
            WAIT_RSP: if (dmem_rsp_valid || timeout_hit) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            off_l            <= 2'd0;
            f3_l             <= 3'd0;
            wr_en_l          <= 1'b0;
            dmem_addr        <= 32'd0;
            dmem_we          <= 1'b0;
            dmem_be          <= 4'd0;
            dmem_wdata       <= 32'd0;
            memory_result    <= 32'd0;
            memory_rd        <= 5'd0;
            memory_wr_enable <= 1'b0;
            memory_fault     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    memory_rd <= execute_rd;
                    if (!mem_op) begin
                        memory_result    <= execute_alu_result;
                        memory_wr_enable <= execute_wr_enable;
                        memory_fault     <= 1'b0;
                    end else if (bad_op) begin
                        memory_wr_enable <= 1'b0;
                        memory_fault     <= 1'b1;
                    end else begin
                        // Request fields are registered here and held until accepted
                        off_l            <= execute_alu_result[1:0];
                        f3_l             <= execute_funct3;
                        wr_en_l          <= execute_wr_enable;
                        memory_wr_enable <= 1'b0;
                        dmem_addr        <= {execute_alu_result[31:2], 2'b00};
                        dmem_we          <= is_store;
                        dmem_be          <= is_store ? store_be(execute_funct3, execute_alu_result[1:0]) : 4'b0000;
                        dmem_wdata       <= is_store ? store_wdata(execute_funct3, execute_store_data) : 32'd0;
                    end
                end
                REQ: cnt <= 8'd0;
                WAIT_RSP: begin
                    // A response arriving on the timeout cycle still completes the load
                    if (dmem_rsp_valid) begin
                        memory_result    <= load_extract(f3_l, off_l, dmem_rsp_data);
                        memory_wr_enable <= wr_en_l;
                    end else if (timeout_hit) begin
                        memory_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    memory_fault     <= 1'b0;
                    memory_wr_enable <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Randomized bench for stage_memory: each instruction is judged against a
// transaction-level model of legality, bus fields, lane extraction and timeout.
module tb_stage_memory;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] execute_alu_result, execute_store_data;
    logic [4:0]  execute_rd;
    logic        execute_wr_enable, execute_mem_to_reg, execute_mem_write;
    logic [2:0]  execute_funct3;
    logic        stall, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rsp_data, memory_result;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid, memory_wr_enable, memory_fault;
    logic [4:0]  memory_rd;

    int n_checks = 0;
    int n_errors = 0;
    bit prev_mem = 0;

    always #5 clk = ~clk;

    stage_memory #(.RSP_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .execute_alu_result(execute_alu_result), .execute_store_data(execute_store_data),
        .execute_rd(execute_rd), .execute_wr_enable(execute_wr_enable),
        .execute_mem_to_reg(execute_mem_to_reg), .execute_mem_write(execute_mem_write),
        .execute_funct3(execute_funct3), .stall(stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .memory_result(memory_result), .memory_rd(memory_rd),
        .memory_wr_enable(memory_wr_enable), .memory_fault(memory_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 when funct3 encodes no size
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit op_legal(input bit ld, input bit st, input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = size_of(f3);
        if (ld && st) return 0;
        if (n == 0) return 0;
        if (st && f3[2]) return 0;
        return (int'(off) % n) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int n;
        logic [31:0] v, m;
        n = size_of(f3);
        if (n == 4) return w;
        v = w >> (8 * int'(off));
        m = (32'h1 << (8 * n)) - 32'h1;
        v = v & m;
        if (!f3[2] && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = size_of(f3);
        return 4'(((1 << n) - 1) << int'(off));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        logic [31:0] w;
        n = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    // dly_req/dly_rsp < 0 pick random bus timing; rsp_word is used when dly_rsp >= 0
    task automatic do_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic we, input logic ld, input logic st, input logic [2:0] f3,
                         input int dly_req, input int dly_rsp, input logic [31:0] rsp_word);
        int d, r;
        logic [31:0] word;
        @(posedge clk); #1;
        execute_alu_result = alu; execute_store_data = sd; execute_rd = rd;
        execute_wr_enable = we; execute_mem_to_reg = ld; execute_mem_write = st;
        execute_funct3 = f3; dmem_req_ready = 0; dmem_rsp_valid = 0;
        if (!(ld || st)) begin
            dmem_rsp_valid = 1'($urandom_range(0, 1)); dmem_rsp_data = $urandom;
            @(negedge clk);
            check_eq("pass_stall", stall, 0);
            check_eq("pass_req_valid", dmem_req_valid, 0);
            if (prev_mem) check_eq("after_done_wr", memory_wr_enable, 0);
            check_eq("idle_fault", memory_fault, 0);
            @(posedge clk); #1; dmem_rsp_valid = 0;
            @(negedge clk);
            check_eq("pass_result", memory_result, alu);
            check_eq("pass_rd", memory_rd, rd);
            check_eq("pass_wr", memory_wr_enable, we);
            check_eq("pass_fault", memory_fault, 0);
            prev_mem = 0;
            return;
        end
        @(negedge clk);
        check_eq("mem_idle_stall", stall, 1);
        check_eq("mem_idle_req", dmem_req_valid, 0);
        if (prev_mem) check_eq("after_done_fault", memory_fault, 0);
        prev_mem = 1;
        if (!op_legal(ld, st, f3, alu[1:0])) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bad_fault", memory_fault, 1);
            check_eq("bad_wr", memory_wr_enable, 0);
            check_eq("bad_stall", stall, 0);
            check_eq("bad_req", dmem_req_valid, 0);
            return;
        end
        d = (dly_req < 0) ? $urandom_range(0, 3) : dly_req;
        for (int k = 0; k <= d; k++) begin
            @(posedge clk); #1;
            dmem_req_ready = (k == d);
            dmem_rsp_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("req_valid", dmem_req_valid, 1);
            check_eq("req_stall", stall, 1);
            check_eq("req_addr", dmem_addr, {alu[31:2], 2'b00});
            check_eq("req_we", dmem_we, st);
            check_eq("req_be", dmem_be, st ? model_be(f3, alu[1:0]) : 4'b0000);
            if (st) check_eq("req_wdata", dmem_wdata, model_wdata(f3, sd));
            check_eq("req_wr", memory_wr_enable, 0);
        end
        @(posedge clk); #1; dmem_req_ready = 0; dmem_rsp_valid = 0;
        if (st) begin
            @(negedge clk);
            check_eq("st_done_stall", stall, 0);
            check_eq("st_done_wr", memory_wr_enable, 0);
            check_eq("st_done_fault", memory_fault, 0);
            check_eq("st_done_req", dmem_req_valid, 0);
            return;
        end
        r = (dly_rsp < 0) ? $urandom_range(1, T + 3) : dly_rsp;
        word = (dly_rsp < 0) ? $urandom : rsp_word;
        for (int j = 1; j <= T; j++) begin
            dmem_rsp_valid = (j == r);
            dmem_rsp_data = (j == r) ? word : $urandom;
            @(negedge clk);
            check_eq("wait_stall", stall, 1);
            check_eq("wait_req", dmem_req_valid, 0);
            check_eq("wait_wr", memory_wr_enable, 0);
            @(posedge clk); #1; dmem_rsp_valid = 0;
            if (j == r) break;
        end
        @(negedge clk);
        check_eq("ld_done_stall", stall, 0);
        if (r <= T) begin
            check_eq("ld_result", memory_result, model_load(f3, alu[1:0], word));
            check_eq("ld_rd", memory_rd, rd);
            check_eq("ld_wr", memory_wr_enable, we);
            check_eq("ld_fault", memory_fault, 0);
        end else begin
            check_eq("timeout_fault", memory_fault, 1);
            check_eq("timeout_wr", memory_wr_enable, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_result"}, memory_result, 0);
        check_eq({tag, "_rd"}, memory_rd, 0);
        check_eq({tag, "_wr"}, memory_wr_enable, 0);
        check_eq({tag, "_fault"}, memory_fault, 0);
        check_eq({tag, "_req"}, dmem_req_valid, 0);
        check_eq({tag, "_addr"}, dmem_addr, 0);
        check_eq({tag, "_we"}, dmem_we, 0);
        check_eq({tag, "_be"}, dmem_be, 0);
        check_eq({tag, "_wdata"}, dmem_wdata, 0);
        check_eq({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, nop_alu;
        logic [2:0] f3;
        int kind;
        bit ld, st;
        rst = 1; execute_alu_result = 0; execute_store_data = 0; execute_rd = 0;
        execute_wr_enable = 0; execute_mem_to_reg = 0; execute_mem_write = 0; execute_funct3 = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1; rst = 0;

        do_op(32'h0000_1234, 0, 5'd5, 1, 0, 0, 3'b000, -1, -1, 0);
        do_op(32'h0000_0101, 0, 5'd7, 1, 1, 0, 3'b000, 0, 1, 32'h1234_8000);
        do_op(32'h0000_0101, 0, 5'd7, 1, 1, 0, 3'b100, 0, 1, 32'h1234_8000);
        do_op(32'h0000_0202, 32'h0000_BEEF, 5'd0, 0, 0, 1, 3'b001, 3, -1, 0);
        do_op(32'h0000_0102, 0, 5'd3, 1, 1, 0, 3'b010, -1, -1, 0);
        do_op(32'h0000_0300, 0, 5'd9, 1, 1, 0, 3'b010, 0, T + 2, 0);
        do_op(32'h0000_5555, 0, 5'd4, 0, 0, 0, 3'b000, -1, -1, 0);
        do_op(32'h0000_0300, 0, 5'd9, 1, 1, 0, 3'b001, 1, T, 32'hCAFE_F00D);
        do_op(32'h0000_0300, 0, 5'd0, 0, 1, 0, 3'b010, 0, 2, 32'h8765_4321);
        do_op(32'h0000_0300, 32'h1122_3344, 5'd1, 1, 1, 1, 3'b010, -1, -1, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            ld = (kind >= 3 && kind <= 5) || kind == 9;
            st = (kind >= 6);
            f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(a, $urandom, 5'($urandom), 1'($urandom), ld, st, f3, -1, -1, 0);
        end

        // Reset while a load waits for its response
        @(posedge clk); #1;
        execute_alu_result = 32'h0000_0400; execute_rd = 5'd6; execute_wr_enable = 1;
        execute_mem_to_reg = 1; execute_mem_write = 0; execute_funct3 = 3'b010;
        @(posedge clk); #1; dmem_req_ready = 1;
        @(posedge clk); #1; dmem_req_ready = 0;
        @(posedge clk); #1;
        nop_alu = $urandom;
        rst = 1; execute_mem_to_reg = 0; execute_alu_result = nop_alu; execute_rd = 5'd2;
        @(posedge clk); #1; rst = 0; dmem_rsp_valid = 1; dmem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1; dmem_rsp_valid = 0;
        @(negedge clk);
        check_eq("postrst_result", memory_result, nop_alu);
        check_eq("postrst_wr", memory_wr_enable, 1);
        check_eq("postrst_fault", memory_fault, 0);
        check_eq("postrst_stall", stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
